// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory slave
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam int   DMEM_WORD_BYTES = 4;
    localparam logic DMEM_RESP_OK    = 1'b0;
    localparam logic DMEM_RESP_ERR   = 1'b1;

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - request/response handshake between LSU and data memory
interface dmem_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - byte-strobed word storage with registered read, contents never reset
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [DMEM_WORD_BYTES-1:0] wr_strb,
    input  logic [31:0]                wr_data,
    input  logic                       rd_en,
    input  logic [IDX_W-1:0]           idx,
    output logic [31:0]                rd_data
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < DMEM_WORD_BYTES; i++) begin
                if (wr_strb[i]) begin
                    mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_slave.sv
// rtl/dmem_slave.sv - data-memory slave with programmable access latency and range checking
module dmem_slave
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    dmem_if.slave  bus
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS * DMEM_WORD_BYTES);
    localparam logic [7:0]  CNT_INIT = 8'(LATENCY - 1);

    dmem_state_e state;
    logic [7:0]  cnt;
    logic [31:0] addr_q;
    logic        wen_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic        rd_sel_q;

    logic        accept;
    logic        access;
    logic [31:0] acc_addr;
    logic        acc_wen;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_wstrb;
    logic [32:0] offset;
    logic        in_range;
    logic [31:0] arr_rdata;

    assign accept = (state == IDLE) && bus.req_valid && req_ready_q;
    assign access = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == 8'd1));

    // A single-cycle build performs the access on the accept edge, before the latch is loaded.
    assign acc_addr  = (state == IDLE) ? bus.req_addr  : addr_q;
    assign acc_wen   = (state == IDLE) ? bus.req_wen   : wen_q;
    assign acc_wdata = (state == IDLE) ? bus.req_wdata : wdata_q;
    assign acc_wstrb = (state == IDLE) ? bus.req_wstrb : wstrb_q;

    // 33-bit subtraction: addresses below BASE_ADDR borrow into bit 32 and fail the compare.
    assign offset   = {1'b0, acc_addr} - {1'b0, BASE_ADDR};
    assign in_range = (offset < SPAN);

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .wr_en   (access && in_range && acc_wen),
        .wr_strb (acc_wstrb),
        .wr_data (acc_wdata),
        .rd_en   (access && in_range && !acc_wen),
        .idx     (offset[IDX_W+1:2]),
        .rd_data (arr_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            addr_q       <= 32'd0;
            wen_q        <= 1'b0;
            wdata_q      <= 32'd0;
            wstrb_q      <= 4'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= DMEM_RESP_OK;
            rd_sel_q     <= 1'b0;
        end else begin
            if (access) begin
                state        <= RESP;
                resp_valid_q <= 1'b1;
                resp_err_q   <= in_range ? DMEM_RESP_OK : DMEM_RESP_ERR;
                rd_sel_q     <= in_range && !acc_wen;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q      <= bus.req_addr;
                        wen_q       <= bus.req_wen;
                        wdata_q     <= bus.req_wdata;
                        wstrb_q     <= bus.req_wstrb;
                        req_ready_q <= 1'b0;
                        if (LATENCY != 1) begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt != 8'd1) begin
                        cnt <= cnt - 8'd1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state        <= IDLE;
                        req_ready_q  <= 1'b1;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= DMEM_RESP_OK;
                        rd_sel_q     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = rd_sel_q ? arr_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_slave.sv
// tb/tb_dmem_slave.sv - directed checks of dmem_slave at latency 2 and latency 1
module tb_dmem_slave;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    dmem_if bus2 ();
    dmem_if bus1 ();

    dmem_slave #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(1024), .LATENCY(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    dmem_slave #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept on the next edge, then scramble req_* to prove the slave latched them.
    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                         input string tag);
        bus2.req_addr  = a;
        bus2.req_wen   = w;
        bus2.req_wdata = d;
        bus2.req_wstrb = s;
        bus2.req_valid = 1'b1;
        step();
        bus2.req_valid = 1'b0;
        bus2.req_addr  = ~a;
        bus2.req_wen   = ~w;
        bus2.req_wdata = ~d;
        bus2.req_wstrb = ~s;
        chk({tag, " wait_valid"}, 32'(bus2.resp_valid), 32'd0);
        chk({tag, " wait_ready"}, 32'(bus2.req_ready), 32'd0);
        step();
        chk({tag, " resp_valid"}, 32'(bus2.resp_valid), 32'd1);
    endtask

    task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] exp_rdata, input logic exp_err, input string tag);
        issue(a, w, d, s, tag);
        chk({tag, " rdata"}, bus2.resp_rdata, exp_rdata);
        chk({tag, " err"}, 32'(bus2.resp_err), 32'(exp_err));
        bus2.resp_ready = 1'b1;
        step();
        bus2.resp_ready = 1'b0;
        chk({tag, " idle_valid"}, 32'(bus2.resp_valid), 32'd0);
        chk({tag, " idle_ready"}, 32'(bus2.req_ready), 32'd1);
        chk({tag, " idle_rdata"}, bus2.resp_rdata, 32'd0);
        chk({tag, " idle_err"}, 32'(bus2.resp_err), 32'd0);
    endtask

    initial begin
        int acc_cycles[$];
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus2.req_valid = 1'b0; bus2.req_addr = 32'd0; bus2.req_wen = 1'b0;
        bus2.req_wdata = 32'd0; bus2.req_wstrb = 4'd0; bus2.resp_ready = 1'b0;
        bus1.req_valid = 1'b0; bus1.req_addr = 32'd0; bus1.req_wen = 1'b0;
        bus1.req_wdata = 32'd0; bus1.req_wstrb = 4'd0; bus1.resp_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        chk("rst req_ready", 32'(bus2.req_ready), 32'd1);
        chk("rst resp_valid", 32'(bus2.resp_valid), 32'd0);
        chk("rst rdata", bus2.resp_rdata, 32'd0);
        chk("rst err", 32'(bus2.resp_err), 32'd0);

        txn(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0, "st_full");
        txn(32'h8000_0010, 1'b0, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0, "ld_full");
        txn(32'h8000_0010, 1'b1, 32'h0000_5500, 4'b0010, 32'd0, 1'b0, "st_byte1");
        txn(32'h8000_0010, 1'b0, 32'd0, 4'h0, 32'hDEAD_55EF, 1'b0, "ld_byte1");
        txn(32'h8000_0010, 1'b1, 32'h1111_1111, 4'b0000, 32'd0, 1'b0, "st_nostrb");
        txn(32'h8000_0010, 1'b0, 32'd0, 4'h0, 32'hDEAD_55EF, 1'b0, "ld_nostrb");

        txn(32'h8000_0000, 1'b1, 32'hA5A5_0001, 4'hF, 32'd0, 1'b0, "st_word0");
        txn(32'h8000_0FFC, 1'b1, 32'h0BAD_CAFE, 4'hF, 32'd0, 1'b0, "st_last");
        txn(32'h8000_0FFC, 1'b0, 32'd0, 4'h0, 32'h0BAD_CAFE, 1'b0, "ld_last");
        txn(32'h8000_1000, 1'b0, 32'd0, 4'h0, 32'd0, 1'b1, "ld_above");
        txn(32'h7FFF_FFFC, 1'b0, 32'd0, 4'h0, 32'd0, 1'b1, "ld_below");
        txn(32'hFFFF_FFFC, 1'b0, 32'd0, 4'h0, 32'd0, 1'b1, "ld_top");
        txn(32'h8000_1000, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b1, "st_above");
        txn(32'h8000_0000, 1'b0, 32'd0, 4'h0, 32'hA5A5_0001, 1'b0, "ld_word0");

        issue(32'h8000_0010, 1'b0, 32'd0, 4'h0, "bp");
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d valid", i), 32'(bus2.resp_valid), 32'd1);
            chk($sformatf("bp%0d rdata", i), bus2.resp_rdata, 32'hDEAD_55EF);
            chk($sformatf("bp%0d err", i), 32'(bus2.resp_err), 32'd0);
            chk($sformatf("bp%0d ready", i), 32'(bus2.req_ready), 32'd0);
            step();
        end
        chk("bp hold valid", 32'(bus2.resp_valid), 32'd1);
        bus2.resp_ready = 1'b1;
        step();
        bus2.resp_ready = 1'b0;
        chk("bp release valid", 32'(bus2.resp_valid), 32'd0);
        chk("bp release ready", 32'(bus2.req_ready), 32'd1);

        bus1.req_addr = 32'h8000_0004; bus1.req_wen = 1'b1;
        bus1.req_wdata = 32'h1122_3344; bus1.req_wstrb = 4'hF; bus1.req_valid = 1'b1;
        step();
        bus1.req_valid = 1'b0;
        chk("l1 st valid", 32'(bus1.resp_valid), 32'd1);
        chk("l1 st err", 32'(bus1.resp_err), 32'd0);
        bus1.resp_ready = 1'b1;
        step();
        bus1.resp_ready = 1'b0;
        bus1.req_wen = 1'b0; bus1.req_valid = 1'b1;
        step();
        bus1.req_valid = 1'b0;
        chk("l1 ld valid", 32'(bus1.resp_valid), 32'd1);
        chk("l1 ld rdata", bus1.resp_rdata, 32'h1122_3344);
        bus1.resp_ready = 1'b1;
        step();
        chk("l1 ld idle", 32'(bus1.resp_valid), 32'd0);

        bus1.req_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (bus1.req_ready) acc_cycles.push_back(c);
            step();
        end
        bus1.req_valid = 1'b0;
        step();
        bus1.resp_ready = 1'b0;
        chk("l1 accept count", 32'(acc_cycles.size()), 32'd4);
        for (int k = 1; k < acc_cycles.size(); k++) begin
            chk($sformatf("l1 spacing%0d", k), 32'(acc_cycles[k] - acc_cycles[k-1]), 32'd2);
        end

        txn(32'h8000_0020, 1'b1, 32'hCAFE_F00D, 4'hF, 32'd0, 1'b0, "st_pre");
        bus2.req_addr = 32'h8000_0020; bus2.req_wen = 1'b1;
        bus2.req_wdata = 32'h1234_5678; bus2.req_wstrb = 4'hF; bus2.req_valid = 1'b1;
        step();
        bus2.req_valid = 1'b0;
        chk("rstw in_wait", 32'(bus2.resp_valid), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstw req_ready", 32'(bus2.req_ready), 32'd1);
        chk("rstw resp_valid", 32'(bus2.resp_valid), 32'd0);
        chk("rstw rdata", bus2.resp_rdata, 32'd0);
        chk("rstw err", 32'(bus2.resp_err), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        txn(32'h8000_0020, 1'b0, 32'd0, 4'h0, 32'hCAFE_F00D, 1'b0, "ld_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_slave.md
Name: dmem_slave

Overview:
Word-organised data-memory slave directly downstream of the load/store unit. It replaces the zero-latency combinational memory path with a valid/ready request/response handshake and a programmable access latency, so the LSU can be made multi-cycle.
It holds an internal byte-writable storage array, commits stores with byte strobes, returns aligned 32-bit read words, and flags out-of-range accesses. Load sign/zero extension and store-data lane placement stay in the LSU.

Parameters:
BASE_ADDR, 32'h8000_0000, byte address of word 0
DEPTH_WORDS, 1024, number of 32-bit words (power of two, >=2)
LATENCY, 2, cycles from request acceptance to resp_valid (>=1, <=255)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset; one clock, asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  slave can accept a request
req_addr  in  32  byte address; bits [1:0] ignored for indexing
req_wen  in  1  1 = store, 0 = load
req_wdata  in  32  store data, already lane-aligned by the LSU
req_wstrb  in  4  byte enables for stores; ignored for loads
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  32  aligned read word (0 for stores and errors)
resp_err  out  1  address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS)

Behaviour:
- Reset (async assert, sync release): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0, latched request cleared. Array contents are NOT reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch addr/wen/wdata/wstrb.
  - If LATENCY==1, go to RESP and perform the access on the same edge.
  - Else go to WAIT with cnt=LATENCY-1.
- WAIT:
  - req_ready=0.
  - If cnt==1, perform the access and go to RESP. Else cnt--.
- Access (single edge, entering RESP):
  - index = (addr-BASE_ADDR)>>2, truncated to $clog2(DEPTH_WORDS) bits.
  - In-range store: write each byte i where wstrb[i]=1. rdata=0, err=0.
  - In-range load: rdata = mem[index], err=0.
  - Out of range: no write, rdata=0, err=1.
  - Range check uses 33-bit arithmetic so there is no wrap at 0xFFFF_FFFF.
- RESP:
  - resp_valid=1. rdata and err are held stable until the handshake.
  - On resp_ready, go to IDLE and clear resp_valid, resp_rdata and resp_err.
  - req_ready=0 throughout RESP, including the handshake cycle. There is no back-to-back accept.
- Latency: a request accepted at edge N has resp_valid=1 from the cycle after edge N+LATENCY-1. Minimum request spacing is LATENCY+1 cycles.
- Ordering: one outstanding transaction. Store data is visible to any later load.
- req_* inputs are don't-care outside IDLE. Changes to them after acceptance have no effect.
- Reset mid-WAIT drops the request; no write occurs. Reset mid-RESP drops the response.
- wstrb=4'b0000 on a store is legal: no write, normal response.

Decomposition:
- Package dmem_pkg: state enum (IDLE/WAIT/RESP), DMEM_WORD_BYTES=4, response-error code constant.
- One sub-module, dmem_array: synchronous byte-strobed write, registered read; parameter DEPTH_WORDS; no reset.

Test Plan:
- Reset then LATENCY=2: store 0x8000_0010, wdata 0xDEADBEEF, wstrb 4'hF -> resp_valid on 2nd cycle after accept, err=0. Load same address -> rdata 0xDEADBEEF.
- Byte strobe: after the above, store 0x8000_0010, wdata 0x0000_5500, wstrb 4'b0010 -> subsequent load returns 0xDEAD55EF.
- Out of range: load 0x8000_1000 and 0x7FFF_FFFC -> err=1, rdata=0. Store 0x8000_1000 -> err=1, and a load of word 0 is unchanged.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid, rdata and err stable, req_ready=0 throughout. Release -> IDLE next cycle, req_ready=1.
- LATENCY=1 build: load accepted at edge N -> resp_valid high in cycle after edge N. Back-to-back valid gives accepts spaced exactly 2 cycles.
- Async reset asserted in WAIT during a store to 0x8000_0020 (wdata 0x1234_5678) -> outputs immediately at reset values. A subsequent load of 0x8000_0020 returns the pre-existing contents, not 0x1234_5678.
